// File: rtl/gemac_f36_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// gemac_f36_pkg : fifo36 word layout, arbiter state codes and helpers, rev 1.0
// ---------------------------------------------------------------------------
package gemac_f36_pkg;

    localparam int F36_W       = 36;
    localparam int F36_SOF     = 32;
    localparam int F36_EOF     = 33;
    localparam int F36_OCC_LSB = 34;
    localparam int F36_OCC_W   = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PASS  = 2'd1;
    localparam logic [1:0] ST_CLOSE = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    // EOF-only terminator with zero occupancy and zero payload
    localparam logic [F36_W-1:0] F36_CLOSE_WORD =
        (F36_W'(1) << F36_EOF) | (F36_W'(0) << F36_OCC_LSB);

    function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, v} + {7'b0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage : gemac_f36_pkg
`default_nettype wire

// File: rtl/tx_f36_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tx_f36_arbiter_if : fifo36 data/src_rdy/dst_rdy bundle, rev 1.0
// ---------------------------------------------------------------------------
interface tx_f36_arbiter_if;
    import gemac_f36_pkg::*;

    logic [F36_W-1:0] data;
    logic             src_rdy;
    logic             dst_rdy;

    modport master (output data, output src_rdy, input  dst_rdy);
    modport slave  (input  data, input  src_rdy, output dst_rdy);

endinterface : tx_f36_arbiter_if
`default_nettype wire

// File: rtl/tx_f36_watchdog.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tx_f36_watchdog : source-stall timer with clear/count/hit, rev 1.0
// ---------------------------------------------------------------------------
module tx_f36_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic clear_i,
    input  wire logic count_i,
    output logic      hit_o
);

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // clear beats count so a transfer always restarts the window
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = count_i && !clear_i && (cnt_q == LAST);

endmodule : tx_f36_watchdog
`default_nettype wire

// File: rtl/tx_f36_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tx_f36_arbiter : packet-atomic round-robin share of the GEMAC tx_f36 port, rev 1.0
// ---------------------------------------------------------------------------
module tx_f36_arbiter
    import gemac_f36_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    input  wire logic         enable,
    tx_f36_arbiter_if.slave   in0,
    tx_f36_arbiter_if.slave   in1,
    tx_f36_arbiter_if.master  out,
    output logic              busy,
    output logic              grant,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output logic [7:0]        timeout_cnt,
    output logic [7:0]        drop_cnt
);

    logic [1:0]       state_q, state_d;
    logic             grant_q, grant_d;
    logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;
    logic [7:0]       timeout_cnt_q, timeout_cnt_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic [F36_W-1:0] g_data;
    logic             g_src_rdy;
    logic             g_dst_rdy;
    logic             req0, req1;
    logic             orphan0, orphan1;
    logic             out_xfer;
    logic             wd_clear, wd_count, wd_hit;

    assign g_data    = grant_q ? in1.data    : in0.data;
    assign g_src_rdy = grant_q ? in1.src_rdy : in0.src_rdy;

    assign req0 = in0.src_rdy &  in0.data[F36_SOF];
    assign req1 = in1.src_rdy &  in1.data[F36_SOF];
    // reset_n gating keeps every dst_rdy low while the block is held in reset
    assign orphan0 = in0.src_rdy & ~in0.data[F36_SOF] & reset_n;
    assign orphan1 = in1.src_rdy & ~in1.data[F36_SOF] & reset_n;

    assign out_xfer = g_src_rdy & out.dst_rdy;

    always_comb begin
        out.data    = '0;
        out.src_rdy = 1'b0;
        g_dst_rdy   = 1'b0;
        case (state_q)
            ST_PASS: begin
                out.data    = g_data;
                out.src_rdy = g_src_rdy;
                g_dst_rdy   = out.dst_rdy;
            end
            ST_CLOSE: begin
                out.data    = F36_CLOSE_WORD;
                out.src_rdy = 1'b1;
            end
            ST_FLUSH: begin
                g_dst_rdy   = 1'b1;
            end
            default: ;
        endcase
    end

    assign in0.dst_rdy = (state_q == ST_IDLE) ? orphan0 : (~grant_q & g_dst_rdy);
    assign in1.dst_rdy = (state_q == ST_IDLE) ? orphan1 : ( grant_q & g_dst_rdy);

    // backpressure (src_rdy=1, dst_rdy=0) neither counts nor clears
    assign wd_clear = (state_q != ST_PASS) | out_xfer;
    assign wd_count = (state_q == ST_PASS) & ~g_src_rdy;

    tx_f36_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (wd_clear),
        .count_i (wd_count),
        .hit_o   (wd_hit)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        pkt_cnt0_d    = pkt_cnt0_q;
        pkt_cnt1_d    = pkt_cnt1_q;
        timeout_cnt_d = timeout_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        case (state_q)
            ST_IDLE: begin
                drop_cnt_d = sat_add8(drop_cnt_q, {1'b0, orphan0} + {1'b0, orphan1});
                if (enable && (req0 || req1)) begin
                    grant_d = (req0 && req1) ? ~grant_q : req1;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                // an EOF transfer outranks a coincident timer hit
                if (out_xfer && g_data[F36_EOF]) begin
                    if (grant_q) begin
                        pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
                    end else begin
                        pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
                    end
                    state_d = ST_IDLE;
                end else if (wd_hit) begin
                    state_d = ST_CLOSE;
                end
            end
            ST_CLOSE: begin
                if (out.dst_rdy) begin
                    timeout_cnt_d = sat_add8(timeout_cnt_q, 2'd1);
                    state_d       = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (g_src_rdy && g_data[F36_EOF]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= 1'b1;
            pkt_cnt0_q    <= '0;
            pkt_cnt1_q    <= '0;
            timeout_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            pkt_cnt0_q    <= pkt_cnt0_d;
            pkt_cnt1_q    <= pkt_cnt1_d;
            timeout_cnt_q <= timeout_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign grant       = grant_q;
    assign pkt_cnt0    = pkt_cnt0_q;
    assign pkt_cnt1    = pkt_cnt1_q;
    assign timeout_cnt = timeout_cnt_q;
    assign drop_cnt    = drop_cnt_q;

endmodule : tx_f36_arbiter
`default_nettype wire

// File: tb/tb_tx_f36_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tx_f36_arbiter : scenario tasks plus randomized traffic vs packet-order model
// ---------------------------------------------------------------------------
module tb_tx_f36_arbiter;
    import gemac_f36_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic       busy, grant;
    logic [15:0] pkt_cnt0, pkt_cnt1;
    logic [7:0]  timeout_cnt, drop_cnt;
    int n_pass = 0;
    int n_total = 0;

    tx_f36_arbiter_if u_in0 ();
    tx_f36_arbiter_if u_in1 ();
    tx_f36_arbiter_if u_out ();

    tx_f36_arbiter #(.TIMEOUT(16), .CNT_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .in0         (u_in0),
        .in1         (u_in1),
        .out         (u_out),
        .busy        (busy),
        .grant       (grant),
        .pkt_cnt0    (pkt_cnt0),
        .pkt_cnt1    (pkt_cnt1),
        .timeout_cnt (timeout_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] mkw(input bit sof, input bit eof);
        logic [1:0] occ;
        occ = eof ? 2'($urandom_range(0, 3)) : 2'b00;
        return {occ, eof, sof, 32'($urandom)};
    endfunction

    task automatic idle_inputs();
        u_in0.src_rdy = 1'b0; u_in0.data = '0;
        u_in1.src_rdy = 1'b0; u_in1.data = '0;
        u_out.dst_rdy = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        u_in0.src_rdy = 1'b1; u_in0.data = mkw(0, 0);
        u_in1.src_rdy = 1'b1; u_in1.data = mkw(1, 0);
        u_out.dst_rdy = 1'b1;
        #1 reset_n = 1'b0;
        @(negedge clk);
        n_total++;
        if ({u_out.src_rdy, u_in0.dst_rdy, u_in1.dst_rdy, busy, grant} !== 5'b00001)
            $display("FAIL reset_ctrl: got %b expected 00001",
                     {u_out.src_rdy, u_in0.dst_rdy, u_in1.dst_rdy, busy, grant});
        else n_pass++;
        n_total++;
        if (u_out.data !== 36'h0) $display("FAIL reset_out_data: got %h expected 0", u_out.data);
        else n_pass++;
        n_total++;
        if ({pkt_cnt0, pkt_cnt1, timeout_cnt, drop_cnt} !== 48'h0)
            $display("FAIL reset_counters: got %h expected 0", {pkt_cnt0, pkt_cnt1, timeout_cnt, drop_cnt});
        else n_pass++;
        idle_inputs();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_single_packet();
        logic [35:0] w[5];
        int errs;
        for (int i = 0; i < 5; i++) w[i] = mkw(i == 0, i == 4);
        do_reset(); enable = 1'b1;
        u_in0.src_rdy = 1'b1; u_in0.data = w[0];
        @(negedge clk);
        n_total++;
        if (u_out.src_rdy !== 1'b0) $display("FAIL single_latency_idle: got %b expected 0", u_out.src_rdy);
        else n_pass++;
        step();
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            u_in0.data = w[i];
            @(negedge clk);
            if (!(u_out.src_rdy === 1'b1 && u_out.data === w[i])) errs++;
            step();
        end
        u_in0.src_rdy = 1'b0;
        n_total++;
        if (errs != 0) $display("FAIL single_words: got %0d bad words expected 0", errs);
        else n_pass++;
        n_total++;
        if ({pkt_cnt0, pkt_cnt1, grant, busy} !== {16'd1, 16'd0, 1'b0, 1'b0})
            $display("FAIL single_counts: got %h expected %h", {pkt_cnt0, pkt_cnt1, grant, busy},
                     {16'd1, 16'd0, 1'b0, 1'b0});
        else n_pass++;
    endtask

    // Packets from the two sources; output order from the round-robin rule
    task automatic run_traffic(input string tag, input int np0, input int np1, input bit rnd);
        logic [35:0] s0[$], s1[$], exp_q[$], got_q[$];
        logic [35:0] od;
        int len0[$], len1[$];
        int a, b, i0, i1, cyc, gap0, gap1, ln, nchk;
        bit last, pick, x0, x1, xo;
        for (int k = 0; k < np0; k++) begin
            ln = $urandom_range(1, 6); len0.push_back(ln);
            for (int j = 0; j < ln; j++) s0.push_back(mkw(j == 0, j == ln - 1));
        end
        for (int k = 0; k < np1; k++) begin
            ln = $urandom_range(1, 6); len1.push_back(ln);
            for (int j = 0; j < ln; j++) s1.push_back(mkw(j == 0, j == ln - 1));
        end
        a = 0; b = 0; i0 = 0; i1 = 0; last = 1'b1;
        while (a < np0 || b < np1) begin
            if (a < np0 && b < np1) pick = !last;
            else pick = (a >= np0);
            if (!pick) begin
                for (int j = 0; j < len0[a]; j++) begin exp_q.push_back(s0[i0]); i0++; end
                a++;
            end else begin
                for (int j = 0; j < len1[b]; j++) begin exp_q.push_back(s1[i1]); i1++; end
                b++;
            end
            last = pick;
        end
        cyc = 0; gap0 = 0; gap1 = 0;
        while (got_q.size() < exp_q.size() && cyc < 4000) begin
            if (s0.size() == 0) u_in0.src_rdy = 1'b0;
            else if (rnd && !s0[0][F36_SOF] && gap0 < 3 && $urandom_range(0, 3) == 0) begin
                u_in0.src_rdy = 1'b0; u_in0.data = 36'($urandom); gap0++;
            end else begin
                u_in0.src_rdy = 1'b1; u_in0.data = s0[0]; gap0 = 0;
            end
            if (s1.size() == 0) u_in1.src_rdy = 1'b0;
            else if (rnd && !s1[0][F36_SOF] && gap1 < 3 && $urandom_range(0, 3) == 0) begin
                u_in1.src_rdy = 1'b0; u_in1.data = 36'($urandom); gap1++;
            end else begin
                u_in1.src_rdy = 1'b1; u_in1.data = s1[0]; gap1 = 0;
            end
            u_out.dst_rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            x0 = u_in0.src_rdy & u_in0.dst_rdy;
            x1 = u_in1.src_rdy & u_in1.dst_rdy;
            xo = u_out.src_rdy & u_out.dst_rdy;
            od = u_out.data;
            step();
            if (x0) void'(s0.pop_front());
            if (x1) void'(s1.pop_front());
            if (xo) got_q.push_back(od);
            cyc++;
        end
        idle_inputs();
        n_total++;
        if (cyc >= 4000) $display("FAIL %s_budget: got %0d words expected %0d", tag, got_q.size(), exp_q.size());
        else n_pass++;
        nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nchk; i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL %s_word%0d: got %h expected %h", tag, i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if ({pkt_cnt0, pkt_cnt1, timeout_cnt, drop_cnt} !== {16'(np0), 16'(np1), 8'd0, 8'd0})
            $display("FAIL %s_counts: got %h expected %h", tag, {pkt_cnt0, pkt_cnt1, timeout_cnt, drop_cnt},
                     {16'(np0), 16'(np1), 8'd0, 8'd0});
        else n_pass++;
        step();
    endtask

    task automatic test_round_robin();
        do_reset(); enable = 1'b1;
        run_traffic("rr", 3, 3, 1'b1);
    endtask

    task automatic test_timeout();
        logic [35:0] w[6];
        logic [35:0] v[4];
        int errs;
        for (int i = 0; i < 6; i++) w[i] = mkw(i == 0, i == 5);
        for (int i = 0; i < 4; i++) v[i] = mkw(i == 0, i == 3);
        do_reset(); enable = 1'b1;
        u_in0.src_rdy = 1'b1; u_in0.data = w[0];
        u_in1.src_rdy = 1'b1; u_in1.data = v[0];
        step();
        errs = 0;
        for (int i = 0; i < 2; i++) begin
            u_in0.data = w[i];
            @(negedge clk);
            if (!(u_out.src_rdy === 1'b1 && u_out.data === w[i])) errs++;
            step();
        end
        u_in0.src_rdy = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (u_out.src_rdy !== 1'b0 || u_in1.dst_rdy !== 1'b0) errs++;
            step();
        end
        n_total++;
        if (errs != 0) $display("FAIL timeout_pre_close: got %0d bad cycles expected 0", errs);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({u_out.src_rdy, u_out.data, u_in0.dst_rdy} !== {1'b1, 36'h2_0000_0000, 1'b0})
            $display("FAIL timeout_close_word: got %h expected %h", {u_out.src_rdy, u_out.data, u_in0.dst_rdy},
                     {1'b1, 36'h2_0000_0000, 1'b0});
        else n_pass++;
        step();
        n_total++;
        if (timeout_cnt !== 8'd1) $display("FAIL timeout_cnt: got %0d expected 1", timeout_cnt);
        else n_pass++;
        errs = 0;
        for (int i = 2; i < 6; i++) begin
            u_in0.src_rdy = 1'b1; u_in0.data = w[i];
            @(negedge clk);
            if (u_in0.dst_rdy !== 1'b1 || u_out.src_rdy !== 1'b0 || u_in1.dst_rdy !== 1'b0) errs++;
            step();
        end
        u_in0.src_rdy = 1'b0;
        n_total++;
        if (errs != 0) $display("FAIL timeout_flush: got %0d bad cycles expected 0", errs);
        else n_pass++;
        step();
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            u_in1.data = v[i];
            @(negedge clk);
            if (!(u_out.src_rdy === 1'b1 && u_out.data === v[i])) errs++;
            step();
        end
        u_in1.src_rdy = 1'b0;
        n_total++;
        if (errs != 0) $display("FAIL timeout_next_port1: got %0d bad words expected 0", errs);
        else n_pass++;
        n_total++;
        if ({pkt_cnt0, pkt_cnt1, timeout_cnt} !== {16'd0, 16'd1, 8'd1})
            $display("FAIL timeout_counts: got %h expected %h", {pkt_cnt0, pkt_cnt1, timeout_cnt},
                     {16'd0, 16'd1, 8'd1});
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [35:0] w[4];
        int errs;
        for (int i = 0; i < 4; i++) w[i] = mkw(i == 0, i == 3);
        do_reset(); enable = 1'b1;
        u_in0.src_rdy = 1'b1; u_in0.data = w[0];
        step();
        errs = 0;
        for (int i = 0; i < 2; i++) begin
            u_in0.data = w[i];
            @(negedge clk);
            if (!(u_out.src_rdy === 1'b1 && u_out.data === w[i])) errs++;
            step();
        end
        u_in0.data = w[2]; u_out.dst_rdy = 1'b0;
        repeat (5000) begin
            @(negedge clk);
            if (!(u_out.src_rdy === 1'b1 && u_out.data === w[2] && busy === 1'b1 && u_in0.dst_rdy === 1'b0)) errs++;
            @(posedge clk);
        end
        #1;
        n_total++;
        if ({errs, timeout_cnt} !== {32'd0, 8'd0})
            $display("FAIL backpressure_hold: got errs=%0d timeouts=%0d expected 0/0", errs, timeout_cnt);
        else n_pass++;
        u_out.dst_rdy = 1'b1;
        for (int i = 2; i < 4; i++) begin
            u_in0.data = w[i];
            @(negedge clk);
            if (!(u_out.src_rdy === 1'b1 && u_out.data === w[i])) errs++;
            step();
        end
        u_in0.src_rdy = 1'b0;
        n_total++;
        if ({errs, pkt_cnt0, busy} !== {32'd0, 16'd1, 1'b0})
            $display("FAIL backpressure_complete: got errs=%0d pkt_cnt0=%0d busy=%b expected 0/1/0", errs, pkt_cnt0, busy);
        else n_pass++;
    endtask

    task automatic test_orphan();
        do_reset(); enable = 1'b1;
        u_in1.src_rdy = 1'b1; u_in1.data = mkw(0, 0);
        @(negedge clk);
        n_total++;
        if ({u_in1.dst_rdy, u_out.src_rdy} !== 2'b10)
            $display("FAIL orphan_accept: got %b expected 10", {u_in1.dst_rdy, u_out.src_rdy});
        else n_pass++;
        step();
        u_in1.src_rdy = 1'b0;
        n_total++;
        if ({drop_cnt, busy} !== {8'd1, 1'b0}) $display("FAIL orphan_drop1: got %h expected 010", {drop_cnt, busy});
        else n_pass++;
        enable = 1'b0;
        u_in0.src_rdy = 1'b1; u_in0.data = mkw(0, 1);
        @(negedge clk);
        n_total++;
        if (u_in0.dst_rdy !== 1'b1) $display("FAIL orphan_disabled_accept: got %b expected 1", u_in0.dst_rdy);
        else n_pass++;
        step();
        u_in0.src_rdy = 1'b0;
        n_total++;
        if (drop_cnt !== 8'd2) $display("FAIL orphan_drop2: got %0d expected 2", drop_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_enable();
        logic [35:0] x0, y0;
        int errs;
        x0 = mkw(1, 0); y0 = mkw(1, 1);
        do_reset(); enable = 1'b1;
        u_in1.src_rdy = 1'b1; u_in1.data = y0;
        step();
        u_in1.src_rdy = 1'b0;
        u_in1.data = '0;
        step();
        u_in0.src_rdy = 1'b1; u_in0.data = mkw(1, 0);
        step();
        step();
        u_in0.data = mkw(0, 0);
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if ({u_out.src_rdy, u_out.data, u_in0.dst_rdy, u_in1.dst_rdy, busy, grant} !== {1'b0, 36'h0, 4'b0001})
            $display("FAIL async_reset_outputs: got %h expected %h",
                     {u_out.src_rdy, u_out.data, u_in0.dst_rdy, u_in1.dst_rdy, busy, grant}, {1'b0, 36'h0, 4'b0001});
        else n_pass++;
        enable = 1'b0;
        u_in0.data = x0; u_in1.src_rdy = 1'b1; u_in1.data = y0;
        @(posedge clk); #1 reset_n = 1'b1;
        errs = 0;
        repeat (8) begin
            @(negedge clk);
            if ({busy, u_out.src_rdy, u_in0.dst_rdy, u_in1.dst_rdy} !== 4'b0000) errs++;
            step();
        end
        n_total++;
        if (errs != 0) $display("FAIL enable_low_no_grant: got %0d bad cycles expected 0", errs);
        else n_pass++;
        enable = 1'b1;
        step();
        @(negedge clk);
        n_total++;
        if ({u_out.src_rdy, u_out.data, grant} !== {1'b1, x0, 1'b0})
            $display("FAIL enable_grant_port0: got %h expected %h", {u_out.src_rdy, u_out.data, grant}, {1'b1, x0, 1'b0});
        else n_pass++;
        step();
        do_reset();
    endtask

    task automatic test_random_traffic();
        int np0, np1;
        for (int r = 0; r < 4; r++) begin
            np0 = $urandom_range(0, 5);
            np1 = $urandom_range(0, 5);
            if (np0 == 0 && np1 == 0) np0 = 1;
            do_reset(); enable = 1'b1;
            run_traffic($sformatf("rnd%0d", r), np0, np1, 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_timeout();
        test_backpressure();
        test_orphan();
        test_reset_enable();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_tx_f36_arbiter
`default_nettype wire
